// File: rtl/freq_meter_pkg.sv
// Shared definitions for the frequency/period meter.
// Holds the FSM encoding, the system clock rate and the mode codes.
package freq_meter_pkg;

    localparam int   CLK_HZ      = 12_000_000;
    localparam logic MODE_FREQ   = 1'b0;
    localparam logic MODE_PERIOD = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ARM  = 2'b01,
        MEAS = 2'b10
    } state_t;

endpackage

// File: rtl/freq_meter_if.sv
// Control/result bundle of the frequency meter.
// The master side requests measurements; the slave side (the meter) reports results.
interface freq_meter_if #(
    parameter int CNT_W = 24
);
    logic             start;
    logic             mode;
    logic             abort;
    logic             busy;
    logic [CNT_W-1:0] result;
    logic             result_valid;
    logic             overflow;
    logic             timeout;

    modport master (
        output start, mode, abort,
        input  busy, result, result_valid, overflow, timeout
    );

    modport slave (
        input  start, mode, abort,
        output busy, result, result_valid, overflow, timeout
    );
endinterface

// File: rtl/freq_meter_sig_sync_edge.sv
// Brings an asynchronous signal into the clk_12MHz domain and flags its rising edges.
// Pulses last one clock and trail the input rise by two to three clocks.
module freq_meter_sig_sync_edge (
    input  logic clk_12MHz,
    input  logic reset,
    input  logic sig_i,
    output logic edge_o
);
    logic [2:0] sync_q;

    always_ff @(posedge clk_12MHz or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[1:0], sig_i};
        end
    end

    // Stage 1 may be metastable; only stages 2 and 3 feed logic.
    assign edge_o = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/freq_meter.sv
// Frequency/period meter: counts input edges in a gate window, or times one input period.
// The result and its flags hold until the next completed measurement.
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int CNT_W          = 24,
    parameter int GATE_CYCLES    = CLK_HZ,
    parameter int TIMEOUT_CYCLES = CLK_HZ
) (
    input  logic        clk_12MHz,
    input  logic        reset,
    input  logic        sig_in_i,
    freq_meter_if.slave bus
);
    // Window timers are sized from their limits so a narrow result still allows long gates.
    localparam int                GATE_W    = $clog2(GATE_CYCLES + 1);
    localparam int                TMO_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES);
    localparam logic [TMO_W-1:0]  TMO_LIMIT = TMO_W'(TIMEOUT_CYCLES);

    state_t            state_q, state_d;
    logic              mode_q, mode_d;
    logic [GATE_W-1:0] gateCnt_q, gateCnt_d;
    logic [TMO_W-1:0]  tmoCnt_q, tmoCnt_d;
    logic [CNT_W-1:0]  edgeCnt_q, edgeCnt_d;
    logic [CNT_W-1:0]  perCnt_q, perCnt_d;
    logic              ovf_q, ovf_d;
    logic [CNT_W-1:0]  result_q, result_d;
    logic              overflow_q, overflow_d;
    logic              timeout_q, timeout_d;
    logic              valid_q, valid_d;

    logic              sigEdge;
    logic [CNT_W-1:0]  edgeNext;
    logic              ovfNext;
    logic [TMO_W-1:0]  tmoNext;
    logic              tmoHit;
    logic              perSat;

    freq_meter_sig_sync_edge uSync (
        .clk_12MHz (clk_12MHz),
        .reset     (reset),
        .sig_i     (sig_in_i),
        .edge_o    (sigEdge)
    );

    assign edgeNext = (sigEdge && !(&edgeCnt_q)) ? edgeCnt_q + CNT_W'(1) : edgeCnt_q;
    assign ovfNext  = ovf_q | (sigEdge & (&edgeCnt_q));
    assign tmoNext  = tmoCnt_q + TMO_W'(1);
    assign tmoHit   = (tmoNext == TMO_LIMIT);
    assign perSat   = &perCnt_q;

    always_ff @(posedge clk_12MHz or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            mode_q     <= MODE_FREQ;
            gateCnt_q  <= '0;
            tmoCnt_q   <= '0;
            edgeCnt_q  <= '0;
            perCnt_q   <= '0;
            ovf_q      <= 1'b0;
            result_q   <= '0;
            overflow_q <= 1'b0;
            timeout_q  <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            gateCnt_q  <= gateCnt_d;
            tmoCnt_q   <= tmoCnt_d;
            edgeCnt_q  <= edgeCnt_d;
            perCnt_q   <= perCnt_d;
            ovf_q      <= ovf_d;
            result_q   <= result_d;
            overflow_q <= overflow_d;
            timeout_q  <= timeout_d;
            valid_q    <= valid_d;
        end
    end

    // Abort is tested first in every busy state so it beats any terminal condition.
    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        gateCnt_d  = gateCnt_q;
        tmoCnt_d   = tmoCnt_q;
        edgeCnt_d  = edgeCnt_q;
        perCnt_d   = perCnt_q;
        ovf_d      = ovf_q;
        result_d   = result_q;
        overflow_d = overflow_q;
        timeout_d  = timeout_q;
        valid_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.start && !bus.abort) begin
                    mode_d    = bus.mode;
                    state_d   = (bus.mode == MODE_PERIOD) ? ARM : MEAS;
                    gateCnt_d = '0;
                    tmoCnt_d  = '0;
                    edgeCnt_d = '0;
                    perCnt_d  = '0;
                    ovf_d     = 1'b0;
                end
            end
            ARM: begin
                if (bus.abort) begin
                    state_d = IDLE;
                end else if (tmoHit) begin
                    result_d   = '0;
                    overflow_d = 1'b0;
                    timeout_d  = 1'b1;
                    valid_d    = 1'b1;
                    state_d    = IDLE;
                end else begin
                    tmoCnt_d = tmoNext;
                    if (sigEdge) begin
                        perCnt_d = CNT_W'(1);
                        state_d  = MEAS;
                    end
                end
            end
            MEAS: begin
                if (bus.abort) begin
                    state_d = IDLE;
                end else if (mode_q == MODE_FREQ) begin
                    // An edge landing in the terminal cycle still belongs to this gate.
                    if (gateCnt_q == GATE_LAST) begin
                        result_d   = edgeNext;
                        overflow_d = ovfNext;
                        timeout_d  = 1'b0;
                        valid_d    = 1'b1;
                        state_d    = IDLE;
                    end else begin
                        gateCnt_d = gateCnt_q + GATE_W'(1);
                        edgeCnt_d = edgeNext;
                        ovf_d     = ovfNext;
                    end
                end else if (sigEdge) begin
                    result_d   = perCnt_q;
                    overflow_d = 1'b0;
                    timeout_d  = 1'b0;
                    valid_d    = 1'b1;
                    state_d    = IDLE;
                end else if (tmoHit || perSat) begin
                    result_d   = '0;
                    overflow_d = 1'b0;
                    timeout_d  = 1'b1;
                    valid_d    = 1'b1;
                    state_d    = IDLE;
                end else begin
                    perCnt_d = perCnt_q + CNT_W'(1);
                    tmoCnt_d = tmoNext;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.busy         = (state_q != IDLE);
    assign bus.result       = result_q;
    assign bus.result_valid = valid_q;
    assign bus.overflow     = overflow_q;
    assign bus.timeout      = timeout_q;

endmodule

// File: tb/tb_freq_meter.sv
// Self-checking bench for freq_meter: vector table of measurements plus abort/reset/saturation sequences.
// Inputs change 1 time unit after the rising clock; outputs are read at that same offset.
module tb_freq_meter;

    typedef struct {
        logic mode;
        int   period;
        int   rise;
        int   expResult;
        int   expOvf;
        int   expTmo;
        int   expLatency;
    } vec_t;

    logic clk_12MHz = 1'b0;
    logic reset     = 1'b0;
    logic sigA      = 1'b0;
    logic sigB      = 1'b0;
    logic sawValid  = 1'b0;
    int   passCount = 0;
    int   checkCount = 0;
    vec_t vecs[8];

    freq_meter_if #(.CNT_W(24)) mIf ();
    freq_meter_if #(.CNT_W(4))  sIf ();

    freq_meter #(.CNT_W(24), .GATE_CYCLES(12000), .TIMEOUT_CYCLES(1000)) dut (
        .clk_12MHz (clk_12MHz),
        .reset     (reset),
        .sig_in_i  (sigA),
        .bus       (mIf)
    );

    freq_meter #(.CNT_W(4), .GATE_CYCLES(200), .TIMEOUT_CYCLES(1000)) dutSat (
        .clk_12MHz (clk_12MHz),
        .reset     (reset),
        .sig_in_i  (sigB),
        .bus       (sIf)
    );

    always #5 clk_12MHz = ~clk_12MHz;

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation still running at time %0t, required finish earlier", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checkCount++;
        if (actual == expected) passCount++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    // Square wave whose first rise is at cycle 'rise'; maxRises of 0 means unlimited.
    function automatic logic sigLevel(input int c, input int period, input int rise, input int maxRises);
        if (period == 0 || c < rise) return 1'b0;
        if (maxRises > 0 && (c - rise) / period >= maxRises) return 1'b0;
        return ((c - rise) % period) < (period / 2);
    endfunction

    task automatic runCycles(input int n);
        repeat (n) begin
            @(posedge clk_12MHz); #1;
            if (mIf.result_valid) sawValid = 1'b1;
        end
    endtask

    task automatic applyStimulus(input logic m, input int period, input int rise, input int bound,
                                 output int seen, output int latency, output int res,
                                 output int ovf, output int tmo, output int busyAtValid);
        int c;
        seen = 0; latency = -1; res = -1; ovf = -1; tmo = -1; busyAtValid = -1;
        sigA = 1'b0;
        repeat (4) @(posedge clk_12MHz);
        #1;
        mIf.start = 1'b1;
        mIf.mode  = m;
        @(posedge clk_12MHz); #1;
        mIf.start = 1'b0;
        c = 0;
        sigA = sigLevel(c, period, rise, 0);
        while (seen == 0 && c < bound) begin
            @(posedge clk_12MHz); #1;
            c++;
            sigA = sigLevel(c, period, rise, 0);
            if (mIf.result_valid) begin
                seen        = 1;
                latency     = c;
                res         = int'(mIf.result);
                ovf         = int'(mIf.overflow);
                tmo         = int'(mIf.timeout);
                busyAtValid = int'(mIf.busy);
            end
        end
        sigA = 1'b0;
    endtask

    task automatic applySatStimulus(input int rises, output int seen, output int latency,
                                    output int res, output int ovf, output int tmo);
        int c;
        seen = 0; latency = -1; res = -1; ovf = -1; tmo = -1;
        sigB = 1'b0;
        repeat (4) @(posedge clk_12MHz);
        #1;
        sIf.start = 1'b1;
        sIf.mode  = 1'b0;
        @(posedge clk_12MHz); #1;
        sIf.start = 1'b0;
        c = 0;
        while (seen == 0 && c < 400) begin
            @(posedge clk_12MHz); #1;
            c++;
            sigB = sigLevel(c, 8, 4, rises);
            if (sIf.result_valid) begin
                seen    = 1;
                latency = c;
                res     = int'(sIf.result);
                ovf     = int'(sIf.overflow);
                tmo     = int'(sIf.timeout);
            end
        end
        sigB = 1'b0;
    endtask

    initial begin
        int seen, latency, res, ovf, tmo, busyAtValid;

        // Edge is sampled 3 clocks after a rise, so period mode finishes at rise+period+3.
        vecs[0] = '{1'b1, 120,  10, 120, 0, 0,   133};
        vecs[1] = '{1'b1,   0,   0,   0, 0, 1,  1000};
        vecs[2] = '{1'b1,   4,   5,   4, 0, 0,    12};
        vecs[3] = '{1'b1, 800, 300,   0, 0, 1,  1000};
        vecs[4] = '{1'b0, 120,  60, 100, 0, 0, 12001};
        vecs[5] = '{1'b0, 120, 118, 100, 0, 0, 12001};
        vecs[6] = '{1'b0, 120, 119,  99, 0, 0, 12001};
        vecs[7] = '{1'b1, 600,  50, 600, 0, 0,   653};

        mIf.start = 1'b0; mIf.mode = 1'b0; mIf.abort = 1'b0;
        sIf.start = 1'b0; sIf.mode = 1'b0; sIf.abort = 1'b0;

        repeat (3) @(posedge clk_12MHz);
        #1;
        checkOutput("reset busy",         int'(mIf.busy),         0);
        checkOutput("reset result",       int'(mIf.result),       0);
        checkOutput("reset result_valid", int'(mIf.result_valid), 0);
        checkOutput("reset overflow",     int'(mIf.overflow),     0);
        checkOutput("reset timeout",      int'(mIf.timeout),      0);
        reset = 1'b1;

        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].mode, vecs[i].period, vecs[i].rise,
                          vecs[i].mode ? 1200 : 13000,
                          seen, latency, res, ovf, tmo, busyAtValid);
            checkOutput($sformatf("vec%0d seen", i),     seen,        1);
            checkOutput($sformatf("vec%0d result", i),   res,         vecs[i].expResult);
            checkOutput($sformatf("vec%0d overflow", i), ovf,         vecs[i].expOvf);
            checkOutput($sformatf("vec%0d timeout", i),  tmo,         vecs[i].expTmo);
            checkOutput($sformatf("vec%0d latency", i),  latency,     vecs[i].expLatency);
            checkOutput($sformatf("vec%0d busy", i),     busyAtValid, 0);
        end

        // Abort in frequency MEAS with an ignored start while busy; prior result must survive.
        sawValid = 1'b0;
        @(posedge clk_12MHz); #1;
        mIf.start = 1'b1; mIf.mode = 1'b0;
        @(posedge clk_12MHz); #1;
        mIf.start = 1'b0;
        runCycles(20);
        mIf.start = 1'b1; mIf.mode = 1'b1;
        runCycles(1);
        mIf.start = 1'b0; mIf.mode = 1'b0;
        checkOutput("busy-start busy", int'(mIf.busy), 1);
        runCycles(28);
        mIf.abort = 1'b1;
        runCycles(1);
        mIf.abort = 1'b0;
        checkOutput("abort busy", int'(mIf.busy), 0);
        runCycles(30);
        checkOutput("abort no valid", int'(sawValid),     0);
        checkOutput("abort result",   int'(mIf.result),   600);
        checkOutput("abort timeout",  int'(mIf.timeout),  0);

        // Abort on the exact timeout cycle: abort must win.
        sawValid = 1'b0;
        @(posedge clk_12MHz); #1;
        mIf.start = 1'b1; mIf.mode = 1'b1;
        @(posedge clk_12MHz); #1;
        mIf.start = 1'b0;
        runCycles(999);
        mIf.abort = 1'b1;
        runCycles(1);
        mIf.abort = 1'b0;
        checkOutput("abort-tmo busy", int'(mIf.busy), 0);
        runCycles(5);
        checkOutput("abort-tmo no valid", int'(sawValid),    0);
        checkOutput("abort-tmo timeout",  int'(mIf.timeout), 0);
        checkOutput("abort-tmo result",   int'(mIf.result),  600);

        // start with abort in IDLE stays idle.
        mIf.start = 1'b1; mIf.abort = 1'b1; mIf.mode = 1'b0;
        runCycles(1);
        mIf.start = 1'b0; mIf.abort = 1'b0;
        checkOutput("start+abort busy", int'(mIf.busy), 0);

        // Reset mid-MEAS clears all outputs asynchronously, then a fresh period run works.
        @(posedge clk_12MHz); #1;
        mIf.start = 1'b1; mIf.mode = 1'b0;
        @(posedge clk_12MHz); #1;
        mIf.start = 1'b0;
        runCycles(30);
        checkOutput("pre-reset busy", int'(mIf.busy), 1);
        reset = 1'b0;
        #1;
        checkOutput("midreset busy",         int'(mIf.busy),         0);
        checkOutput("midreset result",       int'(mIf.result),       0);
        checkOutput("midreset result_valid", int'(mIf.result_valid), 0);
        checkOutput("midreset overflow",     int'(mIf.overflow),     0);
        checkOutput("midreset timeout",      int'(mIf.timeout),      0);
        repeat (3) @(posedge clk_12MHz);
        #1;
        reset = 1'b1;
        applyStimulus(1'b1, 120, 10, 1200, seen, latency, res, ovf, tmo, busyAtValid);
        checkOutput("post-reset seen",    seen,        1);
        checkOutput("post-reset result",  res,         120);
        checkOutput("post-reset timeout", tmo,         0);
        checkOutput("post-reset latency", latency,     133);
        checkOutput("post-reset busy",    busyAtValid, 0);

        // 4-bit counter: 20 edges saturate with overflow; exactly 15 saturate without it.
        applySatStimulus(20, seen, latency, res, ovf, tmo);
        checkOutput("sat20 seen",     seen,    1);
        checkOutput("sat20 result",   res,     15);
        checkOutput("sat20 overflow", ovf,     1);
        checkOutput("sat20 timeout",  tmo,     0);
        checkOutput("sat20 latency",  latency, 201);
        applySatStimulus(15, seen, latency, res, ovf, tmo);
        checkOutput("sat15 seen",     seen, 1);
        checkOutput("sat15 result",   res,  15);
        checkOutput("sat15 overflow", ovf,  0);
        applySatStimulus(16, seen, latency, res, ovf, tmo);
        checkOutput("sat16 result",   res,  15);
        checkOutput("sat16 overflow", ovf,  1);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
